// File: rtl/division_pkg.sv
// Shared definitions for the calculator arithmetic units: default Q-format
// constants and the divider's state encoding.
package division_pkg;

  localparam int Q_WIDTH = 24;
  localparam int Q_FBITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/division.sv
// Iterative signed Q-format divider: restoring long division, one quotient bit
// per clock, with divide-by-zero and overflow flags.
module division
  import division_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FBITS = Q_FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val,
  output div_state_e       dbg_state
);

  localparam int ITER = WIDTH + FBITS;
  localparam int DW   = WIDTH + FBITS;
  localparam int CW   = $clog2(ITER + 1);

  // Handshake: start is sampled only in IDLE; busy covers CALC and SIGN;
  // done is a single-cycle pulse, and val/valid/dbz/ovf hold until the next
  // accepted start.
  div_state_e       state_q;
  logic [DW-1:0]    dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic             busy_q, done_q, valid_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] val_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_d;
  logic             q_bit;

  always_comb begin
    mag_a  = a[WIDTH-1] ? -a : a;
    mag_b  = b[WIDTH-1] ? -b : b;
    // Remainder stays below |b| <= 2^(WIDTH-1), so one extra bit covers the shift.
    rem_sh = {rem_q, dvd_q[DW-1]};
    q_bit  = (rem_sh >= {1'b0, mag_b_q});
    rem_d  = q_bit ? WIDTH'(rem_sh - {1'b0, mag_b_q}) : rem_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      mag_b_q <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            mag_b_q <= mag_b;
            dvd_q   <= {mag_a, {FBITS{1'b0}}};
            rem_q   <= '0;
            quo_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            if (b == '0) begin
              dbz_q   <= 1'b1;
              val_q   <= '0;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              cnt_q   <= CW'(ITER);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_q << 1;
          quo_q <= {quo_q[WIDTH-2:0], q_bit};
          // This step produces quotient bit cnt_q-1; bits >= WIDTH-1 overflow.
          if (q_bit && (cnt_q >= CW'(WIDTH))) ovf_q <= 1'b1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= SIGN;
        end
        SIGN: begin
          val_q   <= ovf_q ? '0 : (sign_q ? -quo_q : quo_q);
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          valid_q <= !dbz_q && !ovf_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
  assign val       = val_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_division.sv
// Randomized and directed bench for the Q16.8 divider against an arithmetic
// reference model.
module tb_division;
  import division_pkg::*;

  localparam int W    = 24;
  localparam int F    = 8;
  localparam int ITER = W + F;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy, done, valid, dbz, ovf;
  logic [W-1:0] a, b, val;
  div_state_e   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  division #(.WIDTH(W), .FBITS(F)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .valid(valid), .dbz(dbz), .ovf(ovf),
    .a(a), .b(b), .val(val), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient of (|a| * 2^F) / |b|, truncated toward zero.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output logic [W-1:0] ev, output logic evld,
                       output logic edz, output logic eov);
    longint sa, sb, q;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    ev = '0; evld = 1'b0; edz = 1'b0; eov = 1'b0;
    if (sb == 0) begin
      edz = 1'b1;
    end else begin
      q = ((sa < 0 ? -sa : sa) * (64'sd1 << F)) / (sb < 0 ? -sb : sb);
      if (q >= (64'sd1 << (W - 1))) eov = 1'b1;
      else begin
        ev   = W'(((sa < 0) != (sb < 0)) ? -q : q);
        evld = 1'b1;
      end
    end
  endtask

  // driver: one operation, optional stray start pulse glitch cycles into it
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int glitch);
    logic [W-1:0] ev, got_exp;
    logic evld, edz, eov;
    int cyc, bcnt, exp_lat;
    model(ta, tb, ev, evld, edz, eov);
    exp_q.push_back(ev);
    exp_lat = edz ? 1 : ITER + 2;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 200) begin
      start = (cyc == glitch) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
    end
    got_exp = exp_q.pop_front();
    check("latency", 64'(cyc), 64'(exp_lat));
    check("busy_cycles", 64'(bcnt), edz ? 64'd0 : 64'(ITER + 1));
    check("val", 64'(val), 64'(got_exp));
    check("valid", 64'(valid), 64'(evld));
    check("dbz", 64'(dbz), 64'(edz));
    check("ovf", 64'(ovf), 64'(eov));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("val_hold", 64'(val), 64'(got_exp));
  endtask

  task automatic reset_mid_calc();
    int seen_done;
    @(negedge clk);
    a = 24'd2560; b = 24'd512; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_outputs", {58'd0, busy, done, valid, dbz, ovf}, 64'd0);
    check("rst_val", 64'(val), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    seen_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    rst = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("rst_no_done", 64'(seen_done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {58'd0, busy, done, valid, dbz, ovf}, 64'd0);
    check("reset_val", 64'(val), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b1;

    run_op(24'd2560, 24'd512, -1);
    run_op(-24'sd2560, 24'd512, -1);
    run_op(24'd2560, -24'sd512, -1);
    run_op(-24'sd2560, -24'sd512, -1);
    run_op(24'd2560, 24'd768, -1);
    run_op(24'd256, 24'd65536, -1);
    run_op(24'd0, 24'd1280, -1);
    run_op(24'd2560, 24'd0, -1);
    run_op(24'd32767, 24'd128, -1);
    run_op(-24'sd32768, 24'd128, -1);
    run_op(24'h7FFFFF, 24'd1, -1);
    run_op(24'h800000, 24'd1, -1);
    run_op(24'h800000, 24'h7FFFFF, -1);
    run_op(-24'sd1, 24'd65536, -1);
    run_op(24'd2560, 24'd512, 3);
    run_op(24'd2560, 24'd768, 20);

    reset_mid_calc();
    run_op(24'd2560, 24'd512, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = W'($urandom); rb = W'($urandom); end
        1: begin ra = W'($urandom); rb = W'($urandom_range(1, 4096)); end
        2: begin ra = W'($urandom_range(0, 65535)); rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom); end
        default: begin ra = -W'($urandom_range(0, 100000)); rb = W'($urandom_range(256, 1 << 20)); end
      endcase
      run_op(ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
